// File: rtl/var_rsqrt_unit.sv
// LayerNorm variance, integer standard deviation and reciprocal (2^FRAC_W / std).
// Bit-serial: one sqrt bit per cycle and one quotient bit per cycle.
module var_rsqrt_unit #(
  parameter int EPS    = 1,
  parameter int FRAC_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_Ex_done,
  input  logic [7:0]        i_Ex,
  input  logic              i_Ex2_done,
  input  logic [7:0]        i_Ex2,
  input  logic [1:0]        i_alpha,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_var,
  output logic [7:0]        o_std,
  output logic [FRAC_W:0]   o_inv_std
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_VAR  = 3'd1;
  localparam logic [2:0] S_SQRT = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CNT_W = $clog2(FRAC_W + 1) + 1;

  logic [2:0]       state;
  logic             flag_ex;
  logic             flag_ex2;
  logic [7:0]       ex_r;
  logic [7:0]       ex2_r;
  logic [1:0]       alpha_r;
  logic [16:0]      op_r;
  logic [7:0]       root_r;
  logic [7:0]       rem_r;
  logic [FRAC_W:0]  dvd_r;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       ex_abs;
  logic [14:0]      sq;
  logic [2:0]       shamt;
  logic [13:0]      ex2_val;
  logic [16:0]      var_diff;
  logic [15:0]      var_clamp;
  logic [7:0]       trial;
  logic [15:0]      trial_sq;
  logic [7:0]       root_next;
  logic [8:0]       rem_sh;
  logic             q_bit;
  logic [7:0]       rem_next;
  logic             ex_hit;
  logic             ex2_hit;

  // Variance path: |Ex|^2 is at most 128^2, so 15 bits are enough.
  assign ex_abs    = ex_r[7] ? (~ex_r + 8'd1) : ex_r;
  assign sq        = {7'b0, ex_abs} * {7'b0, ex_abs};
  assign shamt     = 3'd6 - {alpha_r, 1'b0};
  assign ex2_val   = {ex2_r, 6'b0} >> shamt;
  assign var_diff  = {3'b0, ex2_val} - {2'b0, sq};
  assign var_clamp = var_diff[16] ? 16'd0 : var_diff[15:0];

  // Tentatively set the current root bit; keep it only if trial^2 still fits.
  assign trial     = root_r | (8'd1 << cnt[2:0]);
  assign trial_sq  = {8'b0, trial} * {8'b0, trial};
  assign root_next = ({1'b0, trial_sq} <= op_r) ? trial : root_r;

  // Shift-subtract divider; dvd_r shifts dividend bits out and quotient bits in.
  assign rem_sh    = {rem_r, dvd_r[FRAC_W]};
  assign q_bit     = (rem_sh >= {1'b0, o_std});
  assign rem_next  = q_bit ? 8'(rem_sh - {1'b0, o_std}) : rem_sh[7:0];

  assign ex_hit    = i_Ex_done | flag_ex;
  assign ex2_hit   = i_Ex2_done | flag_ex2;

  assign o_done    = (state == S_DONE);
  assign o_busy    = (state != S_IDLE) | flag_ex | flag_ex2;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      flag_ex   <= 1'b0;
      flag_ex2  <= 1'b0;
      ex_r      <= '0;
      ex2_r     <= '0;
      alpha_r   <= '0;
      op_r      <= '0;
      root_r    <= '0;
      rem_r     <= '0;
      dvd_r     <= '0;
      cnt       <= '0;
      o_var     <= '0;
      o_std     <= '0;
      o_inv_std <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_Ex_done) begin
            ex_r    <= i_Ex;
            flag_ex <= 1'b1;
          end
          if (i_Ex2_done) begin
            ex2_r    <= i_Ex2;
            alpha_r  <= i_alpha;
            flag_ex2 <= 1'b1;
          end
          if (ex_hit && ex2_hit) begin
            flag_ex  <= 1'b0;
            flag_ex2 <= 1'b0;
            state    <= S_VAR;
          end
        end
        S_VAR: begin
          o_var  <= var_clamp;
          op_r   <= {1'b0, var_clamp} + 17'(EPS);
          root_r <= '0;
          cnt    <= CNT_W'(7);
          state  <= S_SQRT;
        end
        S_SQRT: begin
          root_r <= root_next;
          if (cnt == '0) begin
            o_std <= root_next;
            rem_r <= '0;
            dvd_r <= {1'b1, {FRAC_W{1'b0}}};
            cnt   <= CNT_W'(FRAC_W);
            state <= S_DIV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          rem_r <= rem_next;
          dvd_r <= {dvd_r[FRAC_W-1:0], q_bit};
          if (cnt == '0) begin
            o_inv_std <= {dvd_r[FRAC_W-1:0], q_bit};
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_var_rsqrt_unit.sv
// Directed-vector bench for var_rsqrt_unit with hand-computed expected values.
module tb_var_rsqrt_unit;

  logic        i_clk;
  logic        i_rstn;
  logic        i_Ex_done;
  logic [7:0]  i_Ex;
  logic        i_Ex2_done;
  logic [7:0]  i_Ex2;
  logic [1:0]  i_alpha;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_var;
  logic [7:0]  o_std;
  logic [12:0] o_inv_std;

  int n_vec = 0;
  int n_err = 0;

  var_rsqrt_unit #(.EPS(1), .FRAC_W(12)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_Ex_done  (i_Ex_done),
    .i_Ex       (i_Ex),
    .i_Ex2_done (i_Ex2_done),
    .i_Ex2      (i_Ex2),
    .i_alpha    (i_alpha),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_var      (o_var),
    .o_std      (o_std),
    .o_inv_std  (o_inv_std)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Each pulse task drives before an edge, returns #1 after the capture edge.
  task automatic pulse_ex(input logic [7:0] ex);
    @(negedge i_clk);
    i_Ex = ex; i_Ex_done = 1'b1;
    @(posedge i_clk); #1;
    i_Ex_done = 1'b0;
  endtask

  task automatic pulse_ex2(input logic [7:0] ex2, input logic [1:0] a);
    @(negedge i_clk);
    i_Ex2 = ex2; i_alpha = a; i_Ex2_done = 1'b1;
    @(posedge i_clk); #1;
    i_Ex2_done = 1'b0;
  endtask

  task automatic pulse_pair(input logic [7:0] ex, input logic [7:0] ex2, input logic [1:0] a);
    @(negedge i_clk);
    i_Ex = ex; i_Ex2 = ex2; i_alpha = a;
    i_Ex_done = 1'b1; i_Ex2_done = 1'b1;
    @(posedge i_clk); #1;
    i_Ex_done = 1'b0; i_Ex2_done = 1'b0;
  endtask

  // Counts edges since the completing capture until o_done; bounded.
  task automatic wait_done(input string tag, input int start, input logic [15:0] ev,
                           input logic [7:0] es, input logic [12:0] ei);
    int lat;
    logic got;
    lat = start;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd22);
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd1);
    check({tag, "_var"}, 32'(o_var), 32'(ev));
    check({tag, "_std"}, 32'(o_std), 32'(es));
    check({tag, "_inv_std"}, 32'(o_inv_std), 32'(ei));
    @(posedge i_clk); #1;
    check({tag, "_done_pulse_end"}, 32'(o_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_var_hold"}, 32'(o_var), 32'(ev));
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge i_clk); #1;
      if (o_done) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    i_rstn = 1'b0;
    i_Ex_done = 1'b0; i_Ex = '0;
    i_Ex2_done = 1'b0; i_Ex2 = '0; i_alpha = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_var", 32'(o_var), 32'd0);
    check("rst_std", 32'(o_std), 32'd0);
    check("rst_inv", 32'(o_inv_std), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // 1: 25 - 9 = 16, sqrt(17) = 4, 4096/4 = 1024
    pulse_pair(8'd3, 8'd25, 2'd0);
    check("c1_busy_rise", 32'(o_busy), 32'd1);
    wait_done("c1", 0, 16'd16, 8'd4, 13'd1024);

    // 2: 200<<4 = 3200, -20^2 = 400 -> 2800; sqrt(2801) = 52; 4096/52 = 78
    pulse_ex2(8'd200, 2'd2);
    check("c2_busy_after_first", 32'(o_busy), 32'd1);
    repeat (2) @(posedge i_clk);
    #1;
    check("c2_waiting_no_done", 32'(o_done), 32'd0);
    pulse_ex(8'hEC);
    wait_done("c2", 0, 16'd2800, 8'd52, 13'd78);

    // 3: 50 - 100 < 0 -> clamp 0; sqrt(1) = 1; 4096
    pulse_pair(8'd10, 8'd50, 2'd0);
    wait_done("c3", 0, 16'd0, 8'd1, 13'd4096);

    // 4: Ex first (overwritten), then Ex2: 255<<6 = 16320; sqrt(16321) = 127; 32
    pulse_ex(8'd5);
    pulse_ex(8'd0);
    pulse_ex2(8'd255, 2'd3);
    wait_done("c4", 0, 16'd16320, 8'd127, 13'd32);

    // 5: a second pair during SQRT is ignored and leaves no flags behind
    pulse_pair(8'd3, 8'd25, 2'd0);
    repeat (3) @(posedge i_clk);
    pulse_pair(8'd10, 8'd50, 2'd0);
    wait_done("c5", 4, 16'd16, 8'd4, 13'd1024);
    watch_no_done("c5_no_second_done", 30);
    check("c5_flags_clear", 32'(o_busy), 32'd0);

    // 6: reset during DIV aborts asynchronously
    pulse_pair(8'hEC, 8'd200, 2'd2);
    repeat (15) @(posedge i_clk);
    #3;
    i_rstn = 1'b0;
    #1;
    check("c6_rst_busy", 32'(o_busy), 32'd0);
    check("c6_rst_done", 32'(o_done), 32'd0);
    check("c6_rst_var", 32'(o_var), 32'd0);
    check("c6_rst_std", 32'(o_std), 32'd0);
    check("c6_rst_inv", 32'(o_inv_std), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    watch_no_done("c6_no_done_after_abort", 30);
    pulse_pair(8'hEC, 8'd200, 2'd2);
    wait_done("c6_after", 0, 16'd2800, 8'd52, 13'd78);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
